// File: rtl/ctrl_pkg.sv
// ctrl_pkg: shared encodings for the multi-cycle controller.
// Holds the FSM state codes, the opcode constants used by the decoder,
// the alu_op codes and the one-hot instruction class payload.
package ctrl_pkg;

    localparam int unsigned STATE_W = 3;
    localparam int unsigned OP_W    = 11;

    localparam logic [2:0] ST_FETCH  = 3'd0;
    localparam logic [2:0] ST_DECODE = 3'd1;
    localparam logic [2:0] ST_EXEC   = 3'd2;
    localparam logic [2:0] ST_MEM    = 3'd3;
    localparam logic [2:0] ST_WB     = 3'd4;

    // Branch opcodes match only on their leading bits
    localparam logic [5:0]  OP_B    = 6'b000101;
    localparam logic [7:0]  OP_CBZ  = 8'b10110100;
    localparam logic [7:0]  OP_CBNZ = 8'b10110101;
    localparam logic [10:0] OP_LDUR = 11'b11111000010;
    localparam logic [10:0] OP_STUR = 11'b11111000000;
    localparam logic [10:0] OP_ADD  = 11'b10001011000;
    localparam logic [10:0] OP_SUB  = 11'b11001011000;
    localparam logic [10:0] OP_AND  = 11'b10001010000;
    localparam logic [10:0] OP_ORR  = 11'b10101010000;

    localparam logic [1:0] ALU_ADD   = 2'b00;
    localparam logic [1:0] ALU_PASS  = 2'b01;
    localparam logic [1:0] ALU_RTYPE = 2'b10;

    typedef struct packed {
        logic r;
        logic ldur;
        logic stur;
        logic cbz;
        logic cbnz;
        logic b;
        logic illegal;
    } op_class_t;

endpackage

// File: rtl/op_decode.sv
// op_decode: maps the latched 11-bit opcode to a one-hot instruction class.
// Ports: i_opcode (opcode bits [31:21]), o_class (one-hot class, illegal if
// no supported pattern matches).
module op_decode
    import ctrl_pkg::*;
(
    input  logic [OP_W-1:0] i_opcode,
    output op_class_t       o_class
);

    // Patterns are mutually exclusive, so a plain priority chain is one-hot
    always_comb begin
        o_class = '0;
        if (i_opcode[10:5] == OP_B) begin
            o_class.b = 1'b1;
        end else if (i_opcode[10:3] == OP_CBZ) begin
            o_class.cbz = 1'b1;
        end else if (i_opcode[10:3] == OP_CBNZ) begin
            o_class.cbnz = 1'b1;
        end else if (i_opcode == OP_LDUR) begin
            o_class.ldur = 1'b1;
        end else if (i_opcode == OP_STUR) begin
            o_class.stur = 1'b1;
        end else if (i_opcode == OP_ADD || i_opcode == OP_SUB ||
                     i_opcode == OP_AND || i_opcode == OP_ORR) begin
            o_class.r = 1'b1;
        end else begin
            o_class.illegal = 1'b1;
        end
    end

endmodule

// File: rtl/multicycle_control.sv
// multicycle_control: FETCH/DECODE/EXEC/MEM/WB controller for a small
// multi-cycle datapath. Control outputs are combinational from the state,
// latched opcode, zero and mem_ready; retired counts completed instructions.
// Ports: clock, reset_n (async active-low), mem_rdata_op, mem_ready, zero;
// datapath strobes/selects, alu_op, illegal pulse, state (debug), retired.
module multicycle_control
    import ctrl_pkg::*;
#(
    parameter int unsigned CNT_W = 16
) (
    input  logic               clock,
    input  logic               reset_n,
    input  logic [OP_W-1:0]    mem_rdata_op,
    input  logic               mem_ready,
    input  logic               zero,
    output logic               pc_write,
    output logic               pc_src,
    output logic               ir_write,
    output logic               i_or_d,
    output logic               mem_read,
    output logic               mem_write,
    output logic               reg2loc,
    output logic               alu_src,
    output logic               mem_to_reg,
    output logic               reg_write,
    output logic [1:0]         alu_op,
    output logic               illegal,
    output logic [STATE_W-1:0] state,
    output logic [CNT_W-1:0]   retired
);

    logic [STATE_W-1:0] r_state;
    logic [OP_W-1:0]    r_opcode;
    logic [CNT_W-1:0]   r_retired;

    logic [STATE_W-1:0] w_next;
    op_class_t          w_cls;
    logic               w_retire;
    logic               w_pc_write, w_pc_src, w_ir_write, w_i_or_d;
    logic               w_mem_read, w_mem_write, w_reg2loc, w_alu_src;
    logic               w_mem_to_reg, w_reg_write, w_illegal;
    logic [1:0]         w_alu_op;

    op_decode u_op_decode (
        .i_opcode (r_opcode),
        .o_class  (w_cls)
    );

    // State register
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) r_state <= ST_FETCH;
        else          r_state <= w_next;
    end

    // Opcode latch, loaded together with the IR
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n)        r_opcode <= '0;
        else if (w_ir_write) r_opcode <= mem_rdata_op;
    end

    // Retired-instruction counter, wraps naturally
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n)      r_retired <= '0;
        else if (w_retire) r_retired <= r_retired + CNT_W'(1);
    end

    // Next state and control decode
    always_comb begin
        w_next       = r_state;
        w_retire     = 1'b0;
        w_pc_write   = 1'b0;
        w_pc_src     = 1'b0;
        w_ir_write   = 1'b0;
        w_i_or_d     = 1'b0;
        w_mem_read   = 1'b0;
        w_mem_write  = 1'b0;
        w_reg2loc    = 1'b0;
        w_alu_src    = 1'b0;
        w_mem_to_reg = 1'b0;
        w_reg_write  = 1'b0;
        w_alu_op     = ALU_ADD;
        w_illegal    = 1'b0;
        case (r_state)
            ST_FETCH: begin
                w_mem_read = 1'b1;
                if (mem_ready) begin
                    w_ir_write = 1'b1;
                    w_pc_write = 1'b1;
                    w_next     = ST_DECODE;
                end
            end
            ST_DECODE: begin
                w_reg2loc = w_cls.stur | w_cls.cbz | w_cls.cbnz;
                if (w_cls.illegal) begin
                    w_illegal = 1'b1;
                    w_next    = ST_FETCH;
                end else begin
                    w_next    = ST_EXEC;
                end
            end
            ST_EXEC: begin
                w_next = ST_FETCH;
                if (w_cls.r) begin
                    w_alu_op = ALU_RTYPE;
                    w_next   = ST_WB;
                end else if (w_cls.ldur || w_cls.stur) begin
                    w_alu_src = 1'b1;
                    w_reg2loc = w_cls.stur;
                    w_next    = ST_MEM;
                end else if (w_cls.cbz || w_cls.cbnz) begin
                    w_alu_op   = ALU_PASS;
                    w_reg2loc  = 1'b1;
                    // Taken when zero matches the branch sense
                    w_pc_write = w_cls.cbz ? zero : ~zero;
                    w_pc_src   = w_pc_write;
                    w_retire   = 1'b1;
                end else if (w_cls.b) begin
                    w_pc_write = 1'b1;
                    w_pc_src   = 1'b1;
                    w_retire   = 1'b1;
                end
            end
            ST_MEM: begin
                w_i_or_d    = 1'b1;
                w_mem_read  = w_cls.ldur;
                w_mem_write = w_cls.stur;
                if (!w_cls.ldur && !w_cls.stur) begin
                    w_next = ST_FETCH;
                end else if (mem_ready) begin
                    w_next   = w_cls.ldur ? ST_WB : ST_FETCH;
                    w_retire = w_cls.stur;
                end
            end
            ST_WB: begin
                w_reg_write  = 1'b1;
                w_mem_to_reg = w_cls.ldur;
                w_retire     = 1'b1;
                w_next       = ST_FETCH;
            end
            default: w_next = ST_FETCH;
        endcase
    end

    // Write strobes are held low for the whole reset assertion
    assign pc_write   = w_pc_write & reset_n;
    assign ir_write   = w_ir_write & reset_n;
    assign reg_write  = w_reg_write & reset_n;
    assign mem_write  = w_mem_write & reset_n;
    assign pc_src     = w_pc_src;
    assign i_or_d     = w_i_or_d;
    assign mem_read   = w_mem_read;
    assign reg2loc    = w_reg2loc;
    assign alu_src    = w_alu_src;
    assign mem_to_reg = w_mem_to_reg;
    assign alu_op     = w_alu_op;
    assign illegal    = w_illegal;
    assign state      = r_state;
    assign retired    = r_retired;

endmodule

// File: tb/tb_multicycle_control.sv
// Testbench for multicycle_control (CNT_W=4 so the counter wrap is reachable).
module tb_multicycle_control;
    import ctrl_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [10:0] mem_rdata_op;
    logic        mem_ready;
    logic        zero;
    logic        pc_write, pc_src, ir_write, i_or_d, mem_read, mem_write;
    logic        reg2loc, alu_src, mem_to_reg, reg_write, illegal;
    logic [1:0]  alu_op;
    logic [2:0]  state;
    logic [3:0]  retired;
    logic [12:0] ctrl;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    multicycle_control #(.CNT_W(4)) dut (
        .clock        (clk),
        .reset_n      (rst_n),
        .mem_rdata_op (mem_rdata_op),
        .mem_ready    (mem_ready),
        .zero         (zero),
        .pc_write     (pc_write),
        .pc_src       (pc_src),
        .ir_write     (ir_write),
        .i_or_d       (i_or_d),
        .mem_read     (mem_read),
        .mem_write    (mem_write),
        .reg2loc      (reg2loc),
        .alu_src      (alu_src),
        .mem_to_reg   (mem_to_reg),
        .reg_write    (reg_write),
        .alu_op       (alu_op),
        .illegal      (illegal),
        .state        (state),
        .retired      (retired)
    );

    // {pw,ps,ir,iod}_{mr,mw,r2l,as}_{m2r,rw}_{alu_op}_{ill}
    assign ctrl = {pc_write, pc_src, ir_write, i_or_d, mem_read, mem_write,
                   reg2loc, alu_src, mem_to_reg, reg_write, alu_op, illegal};

    localparam logic [12:0] C_FETCH  = 13'b1010_1000_00_00_0;
    localparam logic [12:0] C_FWAIT  = 13'b0000_1000_00_00_0;
    localparam logic [12:0] C_NONE   = 13'b0000_0000_00_00_0;
    localparam logic [12:0] C_DR2L   = 13'b0000_0010_00_00_0;
    localparam logic [12:0] C_DILL   = 13'b0000_0000_00_00_1;
    localparam logic [12:0] C_EXR    = 13'b0000_0000_00_10_0;
    localparam logic [12:0] C_EXLD   = 13'b0000_0001_00_00_0;
    localparam logic [12:0] C_EXST   = 13'b0000_0011_00_00_0;
    localparam logic [12:0] C_EXCBT  = 13'b1100_0010_00_01_0;
    localparam logic [12:0] C_EXCBN  = 13'b0000_0010_00_01_0;
    localparam logic [12:0] C_EXB    = 13'b1100_0000_00_00_0;
    localparam logic [12:0] C_MEMLD  = 13'b0001_1000_00_00_0;
    localparam logic [12:0] C_MEMST  = 13'b0001_0100_00_00_0;
    localparam logic [12:0] C_WBR    = 13'b0000_0000_01_00_0;
    localparam logic [12:0] C_WBLD   = 13'b0000_0000_11_00_0;

    localparam logic [10:0] T_ADD  = 11'b10001011000;
    localparam logic [10:0] T_SUB  = 11'b11001011000;
    localparam logic [10:0] T_LDUR = 11'b11111000010;
    localparam logic [10:0] T_STUR = 11'b11111000000;
    localparam logic [10:0] T_CBZ  = 11'b10110100000;
    localparam logic [10:0] T_CBNZ = 11'b10110101000;
    localparam logic [10:0] T_B    = 11'b00010100000;
    localparam logic [10:0] T_ILL  = 11'b11111111111;

    typedef struct {
        logic [10:0] op;
        logic        rdy;
        logic        z;
        logic [2:0]  st;
        logic [12:0] ctl;
        logic [3:0]  ret;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(logic [10:0] op, logic rdy, logic z,
                                logic [2:0] st, logic [12:0] ctl, logic [3:0] ret);
        vec_t v;
        v.op = op; v.rdy = rdy; v.z = z; v.st = st; v.ctl = ctl; v.ret = ret;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // Drive inputs on the falling edge, then let combinational outputs settle
    task automatic apply(input logic [10:0] op, input logic rdy, input logic z);
        @(negedge clk);
        mem_rdata_op = op;
        mem_ready    = rdy;
        zero         = z;
        #1;
    endtask

    int unsigned model_ret;

    initial begin
        rst_n        = 1'b0;
        mem_rdata_op = T_ADD;
        mem_ready    = 1'b1;
        zero         = 1'b0;

        // Main table: one row per clock cycle
        tbl.push_back(mk(T_ADD , 1, 0, 0, C_FETCH, 0));
        tbl.push_back(mk(11'd0 , 0, 0, 1, C_NONE , 0));
        tbl.push_back(mk(11'd0 , 0, 0, 2, C_EXR  , 0));
        tbl.push_back(mk(11'd0 , 1, 0, 4, C_WBR  , 0));
        tbl.push_back(mk(T_LDUR, 0, 0, 0, C_FWAIT, 1));
        tbl.push_back(mk(T_LDUR, 1, 0, 0, C_FETCH, 1));
        tbl.push_back(mk(11'd0 , 1, 0, 1, C_NONE , 1));
        tbl.push_back(mk(11'd0 , 1, 0, 2, C_EXLD , 1));
        tbl.push_back(mk(11'd0 , 0, 0, 3, C_MEMLD, 1));
        tbl.push_back(mk(11'd0 , 0, 0, 3, C_MEMLD, 1));
        tbl.push_back(mk(11'd0 , 0, 0, 3, C_MEMLD, 1));
        tbl.push_back(mk(11'd0 , 1, 0, 3, C_MEMLD, 1));
        tbl.push_back(mk(11'd0 , 1, 0, 4, C_WBLD , 1));
        tbl.push_back(mk(T_CBZ , 1, 0, 0, C_FETCH, 2));
        tbl.push_back(mk(11'd0 , 1, 0, 1, C_DR2L , 2));
        tbl.push_back(mk(11'd0 , 1, 1, 2, C_EXCBT, 2));
        tbl.push_back(mk(T_CBNZ, 1, 1, 0, C_FETCH, 3));
        tbl.push_back(mk(11'd0 , 1, 1, 1, C_DR2L , 3));
        tbl.push_back(mk(11'd0 , 1, 1, 2, C_EXCBN, 3));
        tbl.push_back(mk(T_CBNZ, 1, 0, 0, C_FETCH, 4));
        tbl.push_back(mk(11'd0 , 1, 0, 1, C_DR2L , 4));
        tbl.push_back(mk(11'd0 , 1, 0, 2, C_EXCBT, 4));
        tbl.push_back(mk(T_STUR, 1, 0, 0, C_FETCH, 5));
        tbl.push_back(mk(11'd0 , 1, 0, 1, C_DR2L , 5));
        tbl.push_back(mk(11'd0 , 1, 0, 2, C_EXST , 5));
        tbl.push_back(mk(11'd0 , 1, 0, 3, C_MEMST, 5));
        tbl.push_back(mk(T_B   , 1, 0, 0, C_FETCH, 6));
        tbl.push_back(mk(11'd0 , 1, 0, 1, C_NONE , 6));
        tbl.push_back(mk(11'd0 , 1, 0, 2, C_EXB  , 6));
        tbl.push_back(mk(T_ILL , 1, 0, 0, C_FETCH, 7));
        tbl.push_back(mk(11'd0 , 1, 0, 1, C_DILL , 7));
        tbl.push_back(mk(T_SUB , 1, 0, 0, C_FETCH, 7));
        tbl.push_back(mk(11'd0 , 1, 0, 1, C_NONE , 7));
        tbl.push_back(mk(11'd0 , 1, 0, 2, C_EXR  , 7));
        tbl.push_back(mk(11'd0 , 1, 0, 4, C_WBR  , 7));
        tbl.push_back(mk(11'd0 , 0, 0, 0, C_FWAIT, 8));

        // Reset state: strobes low even with mem_ready high in FETCH
        #2;
        chk("rst_state", 16'(state), 16'd0);
        chk("rst_retired", 16'(retired), 16'd0);
        chk("rst_pc_write", 16'(pc_write), 16'd0);
        chk("rst_ir_write", 16'(ir_write), 16'd0);

        @(negedge clk);
        mem_ready = 1'b0;
        rst_n     = 1'b1;

        foreach (tbl[i]) begin
            apply(tbl[i].op, tbl[i].rdy, tbl[i].z);
            chk($sformatf("row%0d_state", i), 16'(state), 16'(tbl[i].st));
            chk($sformatf("row%0d_ctrl", i), 16'(ctrl), 16'(tbl[i].ctl));
            chk($sformatf("row%0d_retired", i), 16'(retired), 16'(tbl[i].ret));
        end

        // Reset asserted mid-MEM of a STUR
        apply(T_STUR, 1, 0);
        apply(11'd0, 1, 0);
        apply(11'd0, 1, 0);
        apply(11'd0, 0, 0);
        chk("stur_mem_state", 16'(state), 16'd3);
        chk("stur_mem_write", 16'(mem_write), 16'd1);
        #2;
        mem_ready = 1'b1;
        rst_n     = 1'b0;
        #1;
        chk("midrst_mem_write", 16'(mem_write), 16'd0);
        chk("midrst_state", 16'(state), 16'd0);
        chk("midrst_retired", 16'(retired), 16'd0);
        chk("midrst_pc_write", 16'(pc_write), 16'd0);
        chk("midrst_ir_write", 16'(ir_write), 16'd0);
        @(negedge clk);
        mem_ready = 1'b0;
        rst_n     = 1'b1;
        for (int k = 0; k < 3; k++) begin
            apply(11'd0, 0, 0);
            chk($sformatf("postrst%0d_state", k), 16'(state), 16'd0);
            chk($sformatf("postrst%0d_mem_write", k), 16'(mem_write), 16'd0);
            chk($sformatf("postrst%0d_retired", k), 16'(retired), 16'd0);
        end

        // Sixteen B instructions wrap the 4-bit counter back to 0
        model_ret = 0;
        for (int k = 0; k < 16; k++) begin
            apply(T_B, 1, 0);
            chk($sformatf("wrap%0d_fetch_ret", k), 16'(retired), 16'(model_ret));
            apply(11'd0, 1, 0);
            apply(11'd0, 1, 0);
            chk($sformatf("wrap%0d_exec", k), 16'(ctrl), 16'(C_EXB));
            model_ret = (model_ret + 1) % 16;
        end
        apply(11'd0, 0, 0);
        chk("wrap_final_retired", 16'(retired), 16'(model_ret));
        chk("wrap_final_state", 16'(state), 16'd0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
